// File: rtl/fsm_vending_pkg.sv
// Shared encodings for the chocolate vending FSM: credit states and coin unit values.
package fsm_vending_pkg;

  // Encodings equal the credit held, in 50-bani units.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    C50  = 2'd1,
    C100 = 2'd2
  } state_t;

  localparam logic [2:0] COIN_50_UNITS  = 3'd1;
  localparam logic [2:0] COIN_1LEU_UNITS = 3'd2;

  function automatic logic [2:0] credit_of(input state_t s);
    case (s)
      IDLE:    credit_of = 3'd0;
      C50:     credit_of = 3'd1;
      C100:    credit_of = 3'd2;
      default: credit_of = 3'd0;
    endcase
  endfunction

  function automatic state_t state_of(input logic [2:0] units);
    case (units)
      3'd1:    state_of = C50;
      3'd2:    state_of = C100;
      default: state_of = IDLE;
    endcase
  endfunction

endpackage

// File: rtl/fsm_vending.sv
// Chocolate vending FSM: accumulates 50-bani / 1-leu coins as state credit and
// emits a registered one-cycle dispense pulse once the price is reached.
module fsm_vending
  import fsm_vending_pkg::*;
#(
  parameter int unsigned PRICE_UNITS = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic load50bani,
  input  logic load1leu,
  output logic out_cioco
);

  localparam logic [2:0] PRICE = 3'(PRICE_UNITS);

  state_t     state_q, state_d;
  logic       out_cioco_q, out_cioco_d;
  logic [2:0] coin_units;
  logic [2:0] total_units;
  logic       state_valid;

  always_comb begin
    state_d     = state_q;
    out_cioco_d = 1'b0;
    coin_units  = (load50bani ? COIN_50_UNITS : '0) + (load1leu ? COIN_1LEU_UNITS : '0);
    total_units = credit_of(state_q) + coin_units;
    state_valid = (state_q == IDLE) || (state_q == C50) || (state_q == C100);

    // An illegal encoding drops any coins of this edge and returns to IDLE.
    if (!state_valid) begin
      state_d = IDLE;
    end else if (total_units >= PRICE) begin
      out_cioco_d = 1'b1;
      state_d     = state_of(total_units - PRICE);
    end else begin
      state_d = state_of(total_units);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      out_cioco_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_cioco_q <= out_cioco_d;
    end
  end

  assign out_cioco = out_cioco_q;

endmodule

// File: tb/tb_fsm_vending.sv
// Self-checking bench for fsm_vending: directed scenarios plus random coins and
// asynchronous resets, compared against a credit/price arithmetic model.
module tb_fsm_vending;

  localparam int PRICE = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load50bani = 1'b0;
  logic load1leu = 1'b0;
  logic out_cioco;

  int total = 0;
  int bad = 0;
  int m_credit = 0;
  int m_out = 0;
  int pulses = 0;

  fsm_vending #(.PRICE_UNITS(PRICE)) dut (
    .clk       (clk),
    .rst       (rst),
    .load50bani(load50bani),
    .load1leu  (load1leu),
    .out_cioco (out_cioco)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_both(input string tag);
    check({tag, "_out"}, int'(out_cioco), m_out);
    check({tag, "_credit"}, int'(dut.state_q), m_credit);
  endtask

  // One rising edge with the given coins, model updated from the pricing rule.
  task automatic step(input logic a, input logic b, input string tag);
    int sum;
    load50bani = a;
    load1leu   = b;
    @(posedge clk);
    if (rst) begin
      m_credit = 0;
      m_out    = 0;
    end else begin
      sum = m_credit + (a ? 1 : 0) + (b ? 2 : 0);
      if (sum >= PRICE) begin
        m_out    = 1;
        m_credit = sum - PRICE;
      end else begin
        m_out    = 0;
        m_credit = sum;
      end
    end
    #1;
    if (m_out == 1) pulses++;
    check_both(tag);
    load50bani = 1'b0;
    load1leu   = 1'b0;
  endtask

  // Reset pulse raised between edges; coins presented during it must be ignored.
  task automatic async_reset(input logic a, input logic b, input string tag);
    #2;
    rst = 1'b1;
    #1;
    m_credit = 0;
    m_out    = 0;
    check_both({tag, "_imm"});
    step(a, b, {tag, "_held"});
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check_both("reset_initial");
    step(1'b1, 1'b1, "reset_coins_ignored");
    rst = 1'b0;

    // Three 50-bani coins: C50, C100, then dispense back to IDLE.
    step(1'b1, 1'b0, "s50_1");
    step(1'b1, 1'b0, "s50_2");
    step(1'b1, 1'b0, "s50_3");
    step(1'b0, 1'b0, "s50_after");

    // 1 leu then 50 bani.
    pulses = 0;
    step(1'b0, 1'b1, "leu_then_50_a");
    step(1'b1, 1'b0, "leu_then_50_b");
    step(1'b0, 1'b0, "leu_then_50_c");
    check("leu_then_50_pulses", pulses, 1);

    // From C100, 1 leu dispenses and carries one unit.
    step(1'b0, 1'b1, "c100_reach");
    step(1'b0, 1'b1, "c100_leu");
    check("c100_leu_state", int'(dut.state_q), 1);
    step(1'b0, 1'b0, "c100_leu_idle");

    // Both coins twice from IDLE: back-to-back dispense.
    step(1'b1, 1'b0, "to_idle");
    step(1'b1, 1'b0, "to_idle2");
    step(1'b1, 1'b1, "both_1");
    step(1'b1, 1'b1, "both_2");
    step(1'b0, 1'b0, "both_after");

    // Async reset from C50, then 1 leu lands in C100 without dispensing.
    step(1'b1, 1'b0, "pre_rst_c50");
    async_reset(1'b1, 1'b1, "rst_mid");
    step(1'b0, 1'b1, "post_rst_leu");
    check("post_rst_state", int'(dut.state_q), 2);

    // Idle hold in C100 for ten cycles.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, "hold_c100");

    // Random coins with occasional asynchronous reset.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 24) == 0)
        async_reset(1'($urandom), 1'($urandom), "rand_rst");
      else
        step(1'($urandom), 1'($urandom), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fsm_vending.md
FSM_VENDING -- requirements
Module: fsm_vending

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset; the reset port SHALL be named rst.
REQ-002 Parameter PRICE_UNITS, default 3, SHALL set the chocolate price in 50-bani units (3 = 1.50 lei).
REQ-003 clk  input  1  system clock; all state changes occur on its rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 load50bani  input  1  while high, one 50-bani coin is inserted per rising clk edge.
REQ-006 load1leu  input  1  while high, one 1-leu coin (2 units) is inserted per rising clk edge.
REQ-007 out_cioco  output  1  registered one-cycle dispense pulse.

Function
REQ-008 The block SHALL hold its credit as FSM state: IDLE (0 units), C50 (1 unit), C100 (2 units).
REQ-009 On each rising edge, coin value = load50bani*1 + load1leu*2 units; both high SHALL count as 3 units, i.e. both coins accepted.
REQ-010 On each rising edge, total = credit + coin value.
REQ-011 If total < PRICE_UNITS, next credit SHALL be total and out_cioco SHALL be 0.
REQ-012 If total >= PRICE_UNITS, out_cioco SHALL be 1 for exactly the next cycle and next credit SHALL be total - PRICE_UNITS; excess is carried over, not returned.
REQ-013 Transitions with PRICE_UNITS=3: IDLE+50b->C50; IDLE+1leu->C100; C50+50b->C100; C50+1leu->IDLE with dispense; C100+50b->IDLE with dispense; C100+1leu->C50 with dispense; both coins from any state dispense and keep the current credit.
REQ-014 No coin: credit SHALL be held and out_cioco SHALL be 0.
REQ-015 Inputs held high for N edges SHALL count as N coins; there is no edge detection.
REQ-016 out_cioco SHALL be a flop output with no combinational path from inputs.
REQ-017 At most one chocolate SHALL be dispensed per cycle; consecutive dispense pulses on back-to-back cycles are legal.
REQ-018 Arithmetic SHALL use at least 3 bits so that a worst-case total of 5 units does not overflow.
REQ-019 Unreachable state encodings SHALL recover to IDLE on the next edge with out_cioco=0.

Reset
REQ-020 Asserting rst SHALL immediately force state=IDLE, credit=0 and out_cioco=0, independent of clk.
REQ-021 Coins presented while rst is high SHALL be ignored.
REQ-022 Reset asserted mid-purchase SHALL discard any accumulated credit.
REQ-023 After rst deasserts, the first rising edge SHALL process coins normally.

Structure
REQ-024 The state encodings (IDLE, C50, C100) and coin unit values SHALL live in a shared package, e.g. vending_pkg.
REQ-025 The block SHALL be a single module with a state register, next-state logic and an output register; no sub-modules.

Verification
REQ-026 Reset then 50b high for 3 edges: states go C50, C100, IDLE, with out_cioco=1 for exactly one cycle after the 3rd edge.
REQ-027 Reset then 1leu for 1 edge, then 50b for 1 edge: out_cioco pulses once and the final state is IDLE.
REQ-028 From C100, 1leu for 1 edge: out_cioco=1 for one cycle and the state becomes C50.
REQ-029 Both inputs high for 2 edges from IDLE: two consecutive out_cioco pulses and the state stays IDLE.
REQ-030 Reach C50, assert rst asynchronously between edges: state is IDLE and out_cioco=0 immediately; a later single 1leu edge gives C100 with no dispense.
REQ-031 No coins for 10 cycles from C100: state stays C100 and out_cioco stays 0.
